luks_sensor_spi_rx: RTL and testbench



---
 rtl/luks_sensor_spi_rx.sv | 150 +++++++++++++++
 tb/tb_luks_sensor_spi_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/luks_sensor_spi_rx.sv
// luks_sensor_spi_rx: read-only SPI master for the light-sensor ADC.
// Wins the shared SPI bus through a req/gnt handshake, clocks one frame in
// (leading zeros, data MSB-first, trailing don't-care bits) and presents the
// data field as an 8-bit sample with a frame error flag.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   ena                 enables new transactions
//   start               single-cycle conversion request
//   busy                high whenever the FSM is not idle
//   bus_req / bus_gnt   SPI arbiter handshake
//   sensor_cs_n         sensor chip select, active low
//   sensor_sclk         SPI clock, idles high
//   sensor_miso         sensor serial data
//   data                last sample, held between frames
//   data_valid          one-cycle pulse when data updates
//   frame_err           a leading bit was 1; held until the next data_valid
module luks_sensor_spi_rx #(
    parameter int DIV        = 1,
    parameter int FRAME_BITS = 16,
    parameter int LEAD       = 3,
    parameter int DATA_W     = 8,
    parameter int PERIOD     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    output logic              busy,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              sensor_cs_n,
    output logic              sensor_sclk,
    input  logic              sensor_miso,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              frame_err
);

    typedef enum logic [2:0] {IDLE, REQ, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    state_t                  state, next_state;
    logic [CW-1:0]           cnt;
    logic [BW-1:0]           bit_cnt;
    logic                    phase, phase_d;   // 0: sclk low half, 1: sclk high half
    logic [FRAME_BITS-1:0]   shift;
    logic                    auto_tick, trig, tick, counting;
    logic                    cs_n_d, sclk_d, bus_req_d, busy_d, dv_d;

    // Free-running auto-trigger counter; runs regardless of FSM state.
    generate
        if (PERIOD > 0) begin : g_auto
            localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
            localparam logic [PW-1:0] P_M1 = PW'(PERIOD - 1);
            logic [PW-1:0] pcnt;
            always_ff @(posedge clk) begin
                if (!rst_n)            pcnt <= '0;
                else if (pcnt == P_M1) pcnt <= '0;
                else                   pcnt <= pcnt + 1'b1;
            end
            assign auto_tick = (pcnt == P_M1);
        end else begin : g_no_auto
            assign auto_tick = 1'b0;
        end
    endgenerate

    assign trig     = start | auto_tick;
    assign tick     = (cnt == DIV_M1);
    assign counting = (state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; grant is only looked at in REQ
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (ena && trig) next_state = REQ;
            REQ:      if (bus_gnt)     next_state = CS_SETUP;
            CS_SETUP: if (tick)        next_state = SHIFT;
            SHIFT:    if (tick && phase && bit_cnt == LAST_BIT) next_state = CS_HOLD;
            CS_HOLD:  if (tick)        next_state = DONE;
            DONE:                      next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    // Output logic: values for the registered outputs, derived from the
    // state being entered so every pin is a flop.
    always_comb begin
        phase_d   = (state == SHIFT) ? (phase ^ tick) : 1'b0;
        cs_n_d    = !(next_state inside {CS_SETUP, SHIFT, CS_HOLD});
        sclk_d    = !(next_state == SHIFT && !phase_d);
        bus_req_d = next_state inside {REQ, CS_SETUP, SHIFT, CS_HOLD};
        busy_d    = (next_state != IDLE);
        dv_d      = (next_state == DONE);
    end

    // Timing counters and receive shift register. MISO is captured on the
    // edge that ends the low half, i.e. the one that drives sclk 0->1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            cnt   <= (counting && !tick) ? cnt + 1'b1 : '0;
            phase <= phase_d;
            if (state != SHIFT)
                bit_cnt <= '0;
            else if (tick && phase)
                bit_cnt <= bit_cnt + 1'b1;
            if (state == SHIFT && tick && !phase)
                shift <= {shift[FRAME_BITS-2:0], sensor_miso};
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sensor_cs_n <= 1'b1;
            sensor_sclk <= 1'b1;
            bus_req     <= 1'b0;
            busy        <= 1'b0;
            data_valid  <= 1'b0;
            data        <= '0;
            frame_err   <= 1'b0;
        end else begin
            sensor_cs_n <= cs_n_d;
            sensor_sclk <= sclk_d;
            bus_req     <= bus_req_d;
            busy        <= busy_d;
            data_valid  <= dv_d;
            if (dv_d) begin
                data      <= shift[FRAME_BITS-LEAD-1 -: DATA_W];
                frame_err <= |shift[FRAME_BITS-1 -: LEAD];
            end
        end
    end

endmodule

// File: tb/tb_luks_sensor_spi_rx.sv
module tb_luks_sensor_spi_rx;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    // DUT 0: DIV=1, start-only
    logic       rst_n = 1'b0, ena0 = 1'b1, start0 = 1'b0, gnt0 = 1'b1, miso0 = 1'b0;
    logic       busy0, bus_req0, cs_n0, sclk0, dv0, ferr0;
    logic [7:0] data0;

    // DUT 1: DIV=2, PERIOD=100 auto-trigger, MISO tied high
    logic       rst1_n = 1'b0, start1 = 1'b0;
    logic       busy1, bus_req1, cs_n1, sclk1, dv1, ferr1;
    logic [7:0] data1;
    bit         u1_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    luks_sensor_spi_rx #(.DIV(1), .FRAME_BITS(16), .LEAD(3), .DATA_W(8), .PERIOD(0)) u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena0), .start(start0), .busy(busy0),
        .bus_req(bus_req0), .bus_gnt(gnt0), .sensor_cs_n(cs_n0), .sensor_sclk(sclk0),
        .sensor_miso(miso0), .data(data0), .data_valid(dv0), .frame_err(ferr0)
    );

    luks_sensor_spi_rx #(.DIV(2), .FRAME_BITS(16), .LEAD(3), .DATA_W(8), .PERIOD(100)) u1 (
        .clk(clk), .rst_n(rst1_n), .ena(1'b1), .start(start1), .busy(busy1),
        .bus_req(bus_req1), .bus_gnt(1'b1), .sensor_cs_n(cs_n1), .sensor_sclk(sclk1),
        .sensor_miso(1'b1), .data(data1), .data_valid(dv1), .frame_err(ferr1)
    );

    // Sensor model for u0: first bit presented at cs fall, next bit after each sclk rise
    logic [15:0] frame_q = '0;
    logic [15:0] sh = '0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b1;
    int          rises = 0;
    always @(cs_n0 or sclk0) begin
        if (cs_prev && !cs_n0) begin
            sh    = frame_q;
            rises = 0;
            miso0 = sh[15];
        end else if (!cs_n0 && !sclk_prev && sclk0) begin
            rises = rises + 1;
            sh    = {sh[14:0], 1'b0};
            miso0 = sh[15];
        end
        cs_prev   = cs_n0;
        sclk_prev = sclk0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One start-triggered frame on u0; optional grant delay and mid-frame ena drop.
    task automatic run_frame(input logic [15:0] f, input int gdly, input int ena_drop,
                             output int lat, output int cs_low, output bit wait_ok);
        int n;
        int t0;
        bit seen;
        frame_q = f;
        lat     = -1;
        cs_low  = 0;
        wait_ok = 1'b1;
        n       = 0;
        seen    = 1'b0;
        if (gdly > 0) gnt0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        t0     = cyc;
        while (!seen && n < 300) begin
            @(negedge clk);
            start0 = 1'b0;
            n++;
            if (gdly > 0 && n <= gdly + 1 && !(bus_req0 && cs_n0 && sclk0)) wait_ok = 1'b0;
            if (n == gdly + 1) gnt0 = 1'b1;
            if (ena_drop > 0 && n == ena_drop) ena0 = 1'b0;
            if (!cs_n0) cs_low++;
            if (dv0) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end
        end
        gnt0 = 1'b1;
        ena0 = 1'b1;
    endtask

    // Main sequence on u0
    initial begin
        int  lat, csl, guard;
        bit  ok;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n0, 1);
        chk("rst_sclk", sclk0, 1);
        chk("rst_bus_req", bus_req0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_data", data0, 0);
        chk("rst_dv", dv0, 0);
        chk("rst_ferr", ferr0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean frame 0xB3
        run_frame(16'h1660, 0, 0, lat, csl, ok);
        chk("b3_latency", lat, 36);
        chk("b3_data", data0, 8'hB3);
        chk("b3_ferr", ferr0, 0);
        chk("b3_sclk_rises", rises, 16);
        chk("b3_cs_low", csl, 34);
        chk("b3_busy_in_done", busy0, 1);
        // start in the DONE cycle is dropped
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("done_dv_pulse", dv0, 0);
        chk("done_start_busy", busy0, 0);
        chk("done_start_req", bus_req0, 0);
        chk("data_hold", data0, 8'hB3);

        // Leading bit set, data 0x5A
        run_frame(16'h8B40, 0, 0, lat, csl, ok);
        chk("5a_data", data0, 8'h5A);
        chk("5a_ferr", ferr0, 1);
        repeat (3) @(negedge clk);
        chk("ferr_held", ferr0, 1);
        run_frame(16'h0020, 0, 0, lat, csl, ok);
        chk("01_data", data0, 8'h01);
        chk("01_ferr", ferr0, 0);

        // Grant withheld for 10 cycles
        run_frame(16'h1660, 10, 0, lat, csl, ok);
        chk("gnt_wait_pins", ok, 1);
        chk("gnt_latency", lat, 46);
        chk("gnt_data", data0, 8'hB3);

        // Reset pulse during SHIFT bit 7 (cycle start+17)
        frame_q = 16'h0020;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (16) @(negedge clk);
        chk("pre_rst_busy", busy0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_cs_n", cs_n0, 1);
        chk("mid_rst_sclk", sclk0, 1);
        chk("mid_rst_req", bus_req0, 0);
        chk("mid_rst_data", data0, 0);
        chk("mid_rst_busy", busy0, 0);
        repeat (2) @(negedge clk);
        chk("post_rst_no_dv", dv0, 0);
        run_frame(16'h1660, 0, 0, lat, csl, ok);
        chk("post_rst_latency", lat, 36);
        chk("post_rst_data", data0, 8'hB3);

        // ena=0: starts ignored
        ena0 = 1'b0;
        ok   = 1'b1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) start0 = 1'b1;
            if (i == 21) start0 = 1'b0;
            @(negedge clk);
            if (bus_req0 || dv0 || busy0 || !cs_n0) ok = 1'b0;
        end
        chk("ena0_idle", ok, 1);
        ena0 = 1'b1;
        // ena dropped mid-frame: frame completes
        run_frame(16'h8B40, 0, 5, lat, csl, ok);
        chk("ena_drop_latency", lat, 36);
        chk("ena_drop_data", data0, 8'h5A);

        guard = 0;
        while (!u1_done && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("u1_finished", u1_done, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Auto-trigger checks on u1
    initial begin
        int t[4];
        int k;
        int guard;
        bit injected;
        k        = 0;
        guard    = 0;
        injected = 1'b0;
        repeat (3) @(negedge clk);
        rst1_n = 1'b1;
        while (k < 4 && guard < 700) begin
            @(negedge clk);
            guard++;
            start1 = 1'b0;
            if (dv1) begin
                t[k] = cyc;
                if (k == 0) begin
                    chk("auto_data", data1, 8'hFF);
                    chk("auto_ferr", ferr1, 1);
                end
                k++;
            end
            if (k == 2 && !injected && cyc == t[1] + 40) begin
                chk("inject_busy", busy1, 1);
                start1   = 1'b1;
                injected = 1'b1;
            end
        end
        chk("auto_frames", k, 4);
        if (k == 4) begin
            chk("auto_period_1", t[1] - t[0], 100);
            chk("auto_period_2", t[2] - t[1], 100);
            chk("auto_period_3", t[3] - t[2], 100);
        end
        u1_done = 1'b1;
    end

endmodule
